// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg: shared state, instruction-class, rd-source and pc-select encodings for the copperv control sequencer
package control_sequencer_pkg;
  localparam int IT_W = 4;
  localparam int SEL_W = 2;
  localparam int STATE_WIDTH = 3;
  typedef enum logic [STATE_WIDTH-1:0] {FETCH_S, DECODE_S, EXEC_S, MEM_S, WB_S} state_t;
  localparam logic [IT_W-1:0] INST_TYPE_IMM     = 4'd1;
  localparam logic [IT_W-1:0] INST_TYPE_INT_IMM = 4'd2;
  localparam logic [IT_W-1:0] INST_TYPE_INT_REG = 4'd3;
  localparam logic [IT_W-1:0] INST_TYPE_BRANCH  = 4'd4;
  localparam logic [IT_W-1:0] INST_TYPE_JAL     = 4'd5;
  localparam logic [IT_W-1:0] INST_TYPE_LOAD    = 4'd6;
  localparam logic [IT_W-1:0] INST_TYPE_STORE   = 4'd7;
  localparam logic [SEL_W-1:0] RD_DIN_SEL_IMM = 2'd0;
  localparam logic [SEL_W-1:0] RD_DIN_SEL_ALU = 2'd1;
  localparam logic [SEL_W-1:0] RD_DIN_SEL_MEM = 2'd2;
  localparam logic [SEL_W-1:0] RD_DIN_SEL_PC4 = 2'd3;
  localparam logic PC_NEXT_SEL_INC    = 1'b0;
  localparam logic PC_NEXT_SEL_TARGET = 1'b1;
  typedef struct packed {
    logic             inst_fetch;
    logic             data_req;
    logic             data_write;
    logic             rs1_en;
    logic             rs2_en;
    logic             alu_en;
    logic             rd_en;
    logic [SEL_W-1:0] rd_din_sel;
    logic             pc_en;
    logic             pc_next_sel;
    logic             bus_error;
    logic             illegal_inst;
  } ctrl_t;
  function automatic logic [1:0] src_regs(input logic [IT_W-1:0] t);
    return (t == INST_TYPE_INT_REG || t == INST_TYPE_STORE || t == INST_TYPE_BRANCH) ? 2'b11 :
           (t == INST_TYPE_INT_IMM || t == INST_TYPE_LOAD) ? 2'b01 : 2'b00;
  endfunction
  function automatic logic known(input logic [IT_W-1:0] t);
    return t >= INST_TYPE_IMM && t <= INST_TYPE_STORE;
  endfunction
endpackage

// File: rtl/control_sequencer_bus_wait_timer.sv
// bus_wait_timer: counts bus wait cycles and flags expiry at TIMEOUT-1 (never expires when TIMEOUT is 0)
module bus_wait_timer #(
  parameter int TIMEOUT   = 16,
  parameter int CNT_WIDTH = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);
  logic [CNT_WIDTH-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (!rst || clear) r_cnt <= '0;
    else if (count_en) r_cnt <= r_cnt + 1'b1;
  end
  assign expired = (TIMEOUT != 0) && (r_cnt == CNT_WIDTH'(TIMEOUT - 1));
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with bus handshake waits and timeout abort
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int INST_TYPE_WIDTH  = 4,
  parameter int RD_DIN_SEL_WIDTH = 2,
  parameter int TIMEOUT          = 16,
  parameter int CNT_WIDTH        = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [INST_TYPE_WIDTH-1:0]  inst_type,
  input  logic                        inst_valid,
  input  logic                        data_done,
  input  logic                        branch_taken,
  output logic                        inst_fetch,
  output logic                        data_req,
  output logic                        data_write,
  output logic                        rs1_en,
  output logic                        rs2_en,
  output logic                        alu_en,
  output logic                        rd_en,
  output logic [RD_DIN_SEL_WIDTH-1:0] rd_din_sel,
  output logic                        pc_en,
  output logic                        pc_next_sel,
  output logic                        bus_error,
  output logic                        illegal_inst
);
  state_t r_state, w_next;
  logic [INST_TYPE_WIDTH-1:0] r_type;
  logic w_expired, w_abort, w_clear;
  ctrl_t w_c, w_o;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= FETCH_S;
      r_type <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == DECODE_S) r_type <= inst_type;
    end
  end
  always_comb begin
    w_c = '0;
    w_next = r_state;
    w_abort = 1'b0;
    case (r_state)
      FETCH_S: begin
        w_c.inst_fetch = 1'b1;
        w_abort = !inst_valid && w_expired;
        w_c.bus_error = w_abort;
        w_next = inst_valid ? DECODE_S : FETCH_S;
      end
      DECODE_S: begin
        {w_c.rs2_en, w_c.rs1_en} = src_regs(inst_type);
        w_c.illegal_inst = !known(inst_type);
        w_c.pc_en = !known(inst_type);
        w_c.pc_next_sel = PC_NEXT_SEL_INC;
        w_next = !known(inst_type) ? FETCH_S :
                 (inst_type == INST_TYPE_IMM || inst_type == INST_TYPE_JAL) ? WB_S : EXEC_S;
      end
      EXEC_S: begin
        w_c.alu_en = 1'b1;
        w_c.pc_en = r_type == INST_TYPE_BRANCH;
        w_c.pc_next_sel = r_type == INST_TYPE_BRANCH && branch_taken;
        w_next = (r_type == INST_TYPE_LOAD || r_type == INST_TYPE_STORE) ? MEM_S :
                 (r_type == INST_TYPE_BRANCH) ? FETCH_S : WB_S;
      end
      MEM_S: begin
        w_c.data_req = 1'b1;
        w_c.data_write = r_type == INST_TYPE_STORE;
        w_abort = !data_done && w_expired;
        w_c.bus_error = w_abort;
        w_c.pc_en = w_abort || (data_done && r_type != INST_TYPE_LOAD);
        w_c.pc_next_sel = PC_NEXT_SEL_INC;
        w_next = data_done ? (r_type == INST_TYPE_LOAD ? WB_S : FETCH_S) :
                 w_abort ? FETCH_S : MEM_S;
      end
      WB_S: begin
        w_c.rd_en = 1'b1;
        w_c.pc_en = 1'b1;
        w_c.rd_din_sel = r_type == INST_TYPE_IMM ? RD_DIN_SEL_IMM :
                         r_type == INST_TYPE_LOAD ? RD_DIN_SEL_MEM :
                         r_type == INST_TYPE_JAL ? RD_DIN_SEL_PC4 : RD_DIN_SEL_ALU;
        w_c.pc_next_sel = r_type == INST_TYPE_JAL ? PC_NEXT_SEL_TARGET : PC_NEXT_SEL_INC;
        w_next = FETCH_S;
      end
      default: w_next = FETCH_S;
    endcase
  end
  // an abort in FETCH keeps the state, so the counter must restart explicitly
  assign w_clear = (w_next != r_state) || w_abort;
  assign w_o = rst ? w_c : '0;
  bus_wait_timer #(.TIMEOUT(TIMEOUT), .CNT_WIDTH(CNT_WIDTH)) u_timer (
    .clk(clk),
    .rst(rst),
    .clear(w_clear),
    .count_en(r_state == FETCH_S || r_state == MEM_S),
    .expired(w_expired)
  );
  assign inst_fetch   = w_o.inst_fetch;
  assign data_req     = w_o.data_req;
  assign data_write   = w_o.data_write;
  assign rs1_en       = w_o.rs1_en;
  assign rs2_en       = w_o.rs2_en;
  assign alu_en       = w_o.alu_en;
  assign rd_en        = w_o.rd_en;
  assign rd_din_sel   = w_o.rd_din_sel;
  assign pc_en        = w_o.pc_en;
  assign pc_next_sel  = w_o.pc_next_sel;
  assign bus_error    = w_o.bus_error;
  assign illegal_inst = w_o.illegal_inst;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed per-cycle scoreboard bench for control_sequencer with TIMEOUT=4
module tb_control_sequencer;
  import control_sequencer_pkg::*;
  logic clk = 1'b0, rst = 1'b0;
  logic [3:0] inst_type = '0;
  logic inst_valid = 1'b0, data_done = 1'b0, branch_taken = 1'b0;
  logic inst_fetch, data_req, data_write, rs1_en, rs2_en, alu_en, rd_en, pc_en, pc_next_sel, bus_error, illegal_inst;
  logic [1:0] rd_din_sel;
  typedef struct {string nm; logic [12:0] e;} exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  localparam logic [12:0] IF = 13'h1000, DR = 13'h0800, DW = 13'h0400, R1 = 13'h0200, R2 = 13'h0100,
                          AL = 13'h0080, RD = 13'h0040, PC = 13'h0008, PN = 13'h0004, BE = 13'h0002, IL = 13'h0001;
  localparam logic [12:0] S_IMM = 13'h0000, S_ALU = 13'h0010, S_MEM = 13'h0020, S_PC4 = 13'h0030;
  control_sequencer #(.INST_TYPE_WIDTH(4), .RD_DIN_SEL_WIDTH(2), .TIMEOUT(4), .CNT_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .inst_type(inst_type), .inst_valid(inst_valid), .data_done(data_done),
    .branch_taken(branch_taken), .inst_fetch(inst_fetch), .data_req(data_req), .data_write(data_write),
    .rs1_en(rs1_en), .rs2_en(rs2_en), .alu_en(alu_en), .rd_en(rd_en), .rd_din_sel(rd_din_sel),
    .pc_en(pc_en), .pc_next_sel(pc_next_sel), .bus_error(bus_error), .illegal_inst(illegal_inst)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      automatic exp_t x = q.pop_front();
      automatic logic [12:0] a = {inst_fetch, data_req, data_write, rs1_en, rs2_en, alu_en, rd_en,
                                  rd_din_sel, pc_en, pc_next_sel, bus_error, illegal_inst};
      n_cmp++;
      if (a !== x.e) begin
        n_bad++;
        $display("FAIL %s: got %013b expected %013b", x.nm, a, x.e);
      end
    end
  end
  task automatic step(input string nm, input logic iv, input logic [3:0] it, input logic dd, input logic bt, input logic [12:0] e);
    inst_valid = iv;
    inst_type = it;
    data_done = dd;
    branch_taken = bt;
    q.push_back('{nm, e});
    @(posedge clk);
    #1;
  endtask
  initial begin
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step("reset", 1, INST_TYPE_INT_REG, 1, 1, '0);
    rst = 1'b1;
    step("int_imm fetch", 1, 0, 0, 0, IF);
    step("int_imm decode", 0, INST_TYPE_INT_IMM, 0, 0, R1);
    step("int_imm exec", 0, 0, 0, 0, AL);
    step("int_imm wb", 0, 0, 0, 0, RD | S_ALU | PC);
    step("load fetch", 1, 0, 0, 0, IF);
    step("load decode", 0, INST_TYPE_LOAD, 0, 0, R1);
    step("load exec", 0, INST_TYPE_STORE, 0, 0, AL);
    for (int i = 0; i < 3; i++) step("load mem wait", 0, INST_TYPE_STORE, 0, 0, DR);
    step("load mem done", 0, 0, 1, 0, DR);
    step("load wb", 0, 0, 0, 0, RD | S_MEM | PC);
    step("br1 fetch", 1, 0, 0, 0, IF);
    step("br1 decode", 0, INST_TYPE_BRANCH, 0, 0, R1 | R2);
    step("br1 exec", 0, 0, 0, 1, AL | PC | PN);
    step("br0 fetch", 1, 0, 0, 0, IF);
    step("br0 decode", 0, INST_TYPE_BRANCH, 0, 1, R1 | R2);
    step("br0 exec", 0, 0, 0, 0, AL | PC);
    step("imm fetch", 1, 0, 0, 0, IF);
    step("imm decode", 0, INST_TYPE_IMM, 0, 0, '0);
    step("imm wb", 0, 0, 0, 0, RD | S_IMM | PC);
    step("jal fetch", 1, 0, 0, 0, IF);
    step("jal decode", 0, INST_TYPE_JAL, 0, 0, '0);
    step("jal wb", 0, 0, 0, 0, RD | S_PC4 | PC | PN);
    step("ill fetch", 1, 0, 0, 0, IF);
    step("ill decode", 0, 4'd12, 0, 0, IL | PC);
    step("int_reg fetch", 1, 0, 0, 0, IF);
    step("int_reg decode", 0, INST_TYPE_INT_REG, 0, 0, R1 | R2);
    step("int_reg exec", 0, 0, 0, 1, AL);
    step("int_reg wb", 0, 0, 0, 0, RD | S_ALU | PC);
    step("st_to fetch", 1, 0, 0, 0, IF);
    step("st_to decode", 0, INST_TYPE_STORE, 0, 0, R1 | R2);
    step("st_to exec", 0, 0, 0, 0, AL);
    for (int i = 0; i < 3; i++) step("st_to mem wait", 0, 0, 0, 0, DR | DW);
    step("st_to mem abort", 0, 0, 0, 0, DR | DW | BE | PC);
    step("st_ok fetch", 1, 0, 0, 0, IF);
    step("st_ok decode", 0, INST_TYPE_STORE, 0, 0, R1 | R2);
    step("st_ok exec", 0, 0, 0, 0, AL);
    for (int i = 0; i < 3; i++) step("st_ok mem wait", 0, 0, 0, 0, DR | DW);
    step("st_ok mem done", 0, 0, 1, 0, DR | DW | PC);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) step("fetch wait", 0, 0, 0, 0, IF);
      step("fetch timeout", 0, 0, 0, 0, IF | BE);
    end
    step("after to fetch", 1, 0, 0, 0, IF);
    step("after to decode", 0, INST_TYPE_IMM, 0, 0, '0);
    step("after to wb", 0, 0, 0, 0, RD | S_IMM | PC);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
